// File: rtl/video_timing_ctrl_if.sv
// Signal bundle between the video timing controller, the upstream pixel FIFO and the DVI
// encoder. The master modport is the controller side. The slave modport is the environment
// side.
interface video_timing_ctrl_if;
  logic        en;
  logic        src_ready;
  logic        fifo_empty;
  logic        pix_req;
  logic        pHSync;
  logic        pVSync;
  logic        pVDE;
  logic        frame_start;
  logic        busy;
  logic        underrun;
  logic [11:0] hcnt;
  logic [11:0] vcnt;
  logic [15:0] frame_cnt;

  modport master (
    input  en, src_ready, fifo_empty,
    output pix_req, pHSync, pVSync, pVDE, frame_start, busy, underrun, hcnt, vcnt, frame_cnt
  );

  modport slave (
    output en, src_ready, fifo_empty,
    input  pix_req, pHSync, pVSync, pVDE, frame_start, busy, underrun, hcnt, vcnt, frame_cnt
  );
endinterface

// File: rtl/video_timing_ctrl.sv
// Video timing controller for the HDMI output path.
// Runs the h/v pixel counters, registers the sync and data-enable strobes, and pops the pixel
// FIFO one cycle ahead of pVDE. Starts and stops only on frame boundaries.
// The optional completed-frame counter is built when VTC_FRAME_CNT_EN is defined.
module video_timing_ctrl #(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned H_FP     = 110,
  parameter int unsigned H_SYNC   = 40,
  parameter int unsigned H_BP     = 220,
  parameter int unsigned V_ACTIVE = 720,
  parameter int unsigned V_FP     = 5,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 20,
  parameter bit          HS_POL   = 1'b1,
  parameter bit          VS_POL   = 1'b1
) (
  input logic                 PixelClk,
  input logic                 rst,
  video_timing_ctrl_if.master bus
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] HLast   = 12'(HTotal - 1);
  localparam logic [11:0] VLast   = 12'(VTotal - 1);
  localparam logic [11:0] HActEnd = 12'(H_ACTIVE);
  localparam logic [11:0] VActEnd = 12'(V_ACTIVE);
  localparam logic [11:0] HsStart = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HsEnd   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VsStart = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VsEnd   = 12'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e      state_q, state_d;
  logic [11:0] hcnt_q, hcnt_d;
  logic [11:0] vcnt_q, vcnt_d;
  logic        start;
  logic        run;
  logic        h_last;
  logic        v_last;
  logic        active;
  logic        hs_raw;
  logic        vs_raw;
  logic        hs_q;
  logic        vs_q;
  logic        de_q;
  logic        fs_q;
  logic        underrun_q;

  assign run    = (state_q == StRun);
  assign h_last = (hcnt_q == HLast);
  assign v_last = (vcnt_q == VLast);
  assign active = run && (hcnt_q < HActEnd) && (vcnt_q < VActEnd);
  assign hs_raw = run && (hcnt_q >= HsStart) && (hcnt_q < HsEnd);
  assign vs_raw = run && (vcnt_q >= VsStart) && (vcnt_q < VsEnd);

  // Next state and counter stepping; a stop request is honoured only at the last pixel
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    vcnt_d  = vcnt_q;
    start   = 1'b0;
    unique case (state_q)
      StIdle: begin
        hcnt_d = '0;
        vcnt_d = '0;
        if (bus.en && bus.src_ready) begin
          state_d = StRun;
          start   = 1'b1;
        end
      end
      StRun: begin
        if (h_last) begin
          hcnt_d = '0;
          if (v_last) begin
            vcnt_d = '0;
            // Continuation ignores src_ready; only en decides
            if (!bus.en) state_d = StIdle;
          end else begin
            vcnt_d = vcnt_q + 12'd1;
          end
        end else begin
          hcnt_d = hcnt_q + 12'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and counter registers
  always_ff @(posedge PixelClk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
    end
  end

  // Output strobes are the counter-derived values delayed by one pixel clock
  always_ff @(posedge PixelClk or posedge rst) begin
    if (rst) begin
      hs_q <= ~HS_POL;
      vs_q <= ~VS_POL;
      de_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      hs_q <= hs_raw ? HS_POL : ~HS_POL;
      vs_q <= vs_raw ? VS_POL : ~VS_POL;
      de_q <= active;
      fs_q <= run && (hcnt_q == '0) && (vcnt_q == '0);
    end
  end

  // Sticky underrun; a fresh start clears it (pix_req is low in IDLE so the two never collide)
  always_ff @(posedge PixelClk or posedge rst) begin
    if (rst) begin
      underrun_q <= 1'b0;
    end else if (start) begin
      underrun_q <= 1'b0;
    end else if (active && bus.fifo_empty) begin
      underrun_q <= 1'b1;
    end
  end

`ifdef VTC_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  // Completed-frame counter; wraps naturally and only rst clears it
  always_ff @(posedge PixelClk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else if (run && h_last && v_last) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign bus.frame_cnt = frame_cnt_q;
`else
  assign bus.frame_cnt = '0;
`endif

  assign bus.pix_req     = active;
  assign bus.pHSync      = hs_q;
  assign bus.pVSync      = vs_q;
  assign bus.pVDE        = de_q;
  assign bus.frame_start = fs_q;
  assign bus.busy        = run;
  assign bus.underrun    = underrun_q;
  assign bus.hcnt        = hcnt_q;
  assign bus.vcnt        = vcnt_q;

endmodule
